uart_rx_ctrl: RTL and testbench

- Receive-side controller for the UART. It sequences the 8-bit serial-in/parallel-out shift unit.
- Detects the start bit on the serial line and times mid-bit sampling from a clock-cycle divider.
- Issues one shift enable per data bit, checks the stop bit, and presents the assembled byte on a valid/ready interface to the host side.

---
 rtl/uart_rx_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART receive-side controller. Synchronises the serial line,
//               detects the start bit, times mid-bit sampling from a clock
//               divider, sequences an external 8-bit serial-in/parallel-out
//               shift unit (one sipo_shift pulse per data bit), checks the
//               stop bit and presents the received byte on a valid/ready
//               interface.
//
// Optional    : define UART_RX_PARITY_EN to add an even-parity bit between
//               the data bits and the stop bit, plus the parity_err output.
//
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-high reset
//               rx_in      - raw serial line (idles high, asynchronous)
//               sipo_d     - sampled data bit to the shift unit
//               sipo_shift - one-cycle shift enable to the shift unit
//               sipo_q     - parallel contents of the shift unit
//               data_out   - received byte (LSB = first bit on the wire)
//               data_valid - byte available, held until accepted
//               data_ready - host accepts when data_valid && data_ready
//               frame_err  - one-cycle pulse, stop bit sampled low
//               overrun    - one-cycle pulse, byte dropped (holding full)
//               parity_err - one-cycle pulse, parity mismatch (option only)
//               busy       - high whenever not idle
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int CLK_DIV = 16,   // clock cycles per bit, >= 4, even
    parameter int CNT_W   = 8     // 2**CNT_W > CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic       sipo_d,
    output logic       sipo_shift,
    input  logic [7:0] sipo_q,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_STOP   = 3'd3;
    localparam logic [2:0] c_S_BRK    = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_S_PARITY = 3'd5;
`endif

    localparam logic [CNT_W-1:0] c_CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic             r_rx_meta;
    logic             r_rx_s;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       w_rev;
    logic             w_par_bad;

`ifdef UART_RX_PARITY_EN
    logic             r_par;       // running XOR of the sampled data bits
    logic             r_par_bad;   // latched parity verdict for the stop bit
    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif

    // The shift unit moves q[0] toward q[7], so the first bit received ends
    // up in q[7]; reverse to put the first bit on the wire in data_out[0].
    always_comb begin
        w_rev = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w_rev[i] = sipo_q[7-i];
        end
    end

    assign busy = (r_state != c_S_IDLE);

    // Two-flop synchroniser; resets to the idle (high) line level so that a
    // reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            sipo_d     <= 1'b0;
            sipo_shift <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            r_par      <= 1'b0;
            r_par_bad  <= 1'b0;
`endif
        end else begin
            sipo_shift <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // Host handshake; a byte loading in STOP below overrides this.
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            case (r_state)
                c_S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= c_S_START;
                        r_cnt   <= '0;
                    end
                end

                c_S_START: begin
                    if (r_cnt == c_CNT_HALF) begin
                        if (!r_rx_s) begin
                            r_state   <= c_S_DATA;
                            r_cnt     <= '0;
                            r_bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
                            r_par     <= 1'b0;
`endif
                        end else begin
                            // Line back high at mid-start: a glitch.
                            r_state <= c_S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                c_S_DATA: begin
                    if (r_cnt == c_CNT_FULL) begin
                        sipo_d     <= r_rx_s;
                        sipo_shift <= 1'b1;
                        r_cnt      <= '0;
                        r_bit_idx  <= r_bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                        r_par      <= r_par ^ r_rx_s;
`endif
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= c_S_PARITY;
`else
                            r_state <= c_S_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

`ifdef UART_RX_PARITY_EN
                c_S_PARITY: begin
                    if (r_cnt == c_CNT_FULL) begin
                        // Even parity: data XOR parity bit must be zero.
                        r_par_bad <= r_par ^ r_rx_s;
                        r_cnt     <= '0;
                        r_state   <= c_S_STOP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
`endif

                c_S_STOP: begin
                    if (r_cnt == c_CNT_FULL) begin
                        r_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                        parity_err <= r_par_bad;
`endif
                        if (!r_rx_s) begin
                            frame_err <= 1'b1;
                            r_state   <= c_S_BRK;
                        end else begin
                            r_state <= c_S_IDLE;
                            if (!w_par_bad) begin
                                if (!data_valid || data_ready) begin
                                    data_out   <= w_rev;
                                    data_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                c_S_BRK: begin
                    // A held-low (break) line must not look like a new start.
                    if (r_rx_s) begin
                        r_state <= c_S_IDLE;
                    end
                end

                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Self-checking bench for uart_rx_ctrl. Frames are driven onto
//               rx_in bit by bit; a frame-level reference model predicts the
//               host-visible events (accepted byte, frame error, parity
//               error, overrun) and the shift-pulse count per busy episode,
//               and a monitor compares them as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int CLK_DIV = 16;
    localparam int K_ACC   = 0;
    localparam int K_FERR  = 1;
    localparam int K_OVR   = 2;
    localparam int K_PERR  = 3;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // start-bit detect via synchroniser (2), half bit, 8 data + stop bits,
    // optional parity bit, plus one cycle for the output register.
    localparam int LATENCY = 2 + CLK_DIV / 2 + (9 + PAR_BITS) * CLK_DIV + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       sipo_d;
    logic       sipo_shift;
    logic [7:0] sipo_q = 8'h00;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b1;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       busy;

    uart_rx_ctrl #(.CLK_DIV(CLK_DIV), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .sipo_d     (sipo_d),
        .sipo_shift (sipo_shift),
        .sipo_q     (sipo_q),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );
`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always #5 clk = ~clk;

    // External shift unit: q[0] toward q[7], never cleared.
    always @(posedge clk) if (sipo_shift) sipo_q <= {sipo_q[6:0], sipo_d};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    // ---------------- scoreboard / reference model ----------------
    int   exp_kind_q[$];
    int   exp_data_q[$];
    int   exp_shifts_q[$];
    bit   m_held = 0;
    int   m_held_data = 0;
    int   t_start = 0;
    int   t_valid = -1;

    task automatic push_ev(input int kind, input int data);
        exp_kind_q.push_back(kind);
        exp_data_q.push_back(data);
    endtask

    task automatic set_ready(input bit b);
        if (b && m_held) begin
            push_ev(K_ACC, m_held_data);
            m_held = 0;
        end
        data_ready = b;
    endtask

    task automatic drive_bit(input bit b);
        rx_in = b;
        repeat (CLK_DIV) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full frame; expectations are recorded before the line is driven.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_flip);
        bit par_bad;
        par_bad = (PAR_BITS != 0) && par_flip;
        exp_shifts_q.push_back(8);
        if (!stop_ok) begin
            push_ev(K_FERR, 0);
            if (par_bad) push_ev(K_PERR, 0);
        end else if (par_bad) begin
            push_ev(K_PERR, 0);
        end else if (data_ready) begin
            push_ev(K_ACC, d);
        end else if (m_held) begin
            push_ev(K_OVR, 0);
        end else begin
            m_held = 1;
            m_held_data = d;
        end
        rx_in = 1'b0;
        t_start = cyc;
        repeat (CLK_DIV) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_BITS != 0) drive_bit((^d) ^ par_flip);
        drive_bit(stop_ok);
    endtask

    // ---------------- monitor ----------------
    int       ep_shifts = 0;
    int       last_shift = 0;
    bit       prev_busy = 0;
    bit       prev_valid = 0;
    bit       prev_ready = 0;
    logic [7:0] prev_dout = 8'h00;

    task automatic pop_check(input int kind, input int data);
        int ek, ed;
        if (exp_kind_q.size() == 0) begin
            chk("unexpected_event", kind, -1);
        end else begin
            ek = exp_kind_q.pop_front();
            ed = exp_data_q.pop_front();
            chk("event_kind", kind, ek);
            if (ek == K_ACC && kind == K_ACC) chk("rx_byte", data, ed);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            ep_shifts  = 0;
            prev_busy  = 0;
            prev_valid = 0;
        end else begin
            if (sipo_shift) begin
                if (ep_shifts > 0) chk("shift_gap", cyc - last_shift, CLK_DIV);
                ep_shifts++;
                last_shift = cyc;
            end
            if (frame_err)  pop_check(K_FERR, 0);
            if (parity_err) pop_check(K_PERR, 0);
            if (overrun)    pop_check(K_OVR, 0);
            if (data_valid && data_ready) pop_check(K_ACC, int'(data_out));
            if (prev_valid && !prev_ready && data_valid)
                chk("hold_stable", int'(data_out), int'(prev_dout));
            if (data_valid && !prev_valid) t_valid = cyc;
            if (prev_busy && !busy) begin
                if (exp_shifts_q.size() == 0) chk("unexpected_episode", ep_shifts, -1);
                else chk("shifts_per_frame", ep_shifts, exp_shifts_q.pop_front());
                ep_shifts = 0;
            end
            prev_busy  = busy;
            prev_valid = data_valid;
            prev_ready = data_ready;
            prev_dout  = data_out;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", int'({data_out, data_valid, sipo_shift, sipo_d, busy, frame_err, overrun, parity_err}), 0);
        rst = 1'b0;
        idle(5);

        // Basic frame with latency check.
        t_valid = -1;
        send_frame(8'hA5, 1, 0);
        idle(4);
        chk("latency", t_valid - t_start, LATENCY);
        chk("valid_one_cycle", int'(data_valid), 0);
        chk("frame_err_idle", int'(frame_err), 0);

        // Six-cycle glitch while idle.
        exp_shifts_q.push_back(0);
        rx_in = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        idle(14);
        chk("glitch_busy", int'(busy), 0);
        idle(10);

        // Framing error followed by a held break.
        send_frame(8'h3C, 0, 0);
        rx_in = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("break_busy", int'(busy), 1);
        chk("break_valid", int'(data_valid), 0);
        idle(6);
        chk("break_release", int'(busy), 0);
        send_frame(8'h81, 1, 0);
        idle(6);

        // Overrun with host stalled.
        set_ready(0);
        send_frame(8'h11, 1, 0);
        send_frame(8'h22, 1, 0);
        idle(10);
        chk("ovr_held_valid", int'(data_valid), 1);
        chk("ovr_held_data", int'(data_out), 8'h11);
        set_ready(1);
        @(posedge clk);
        #1;
        chk("ovr_drop_valid", int'(data_valid), 0);
        chk("ovr_keep_data", int'(data_out), 8'h11);
        idle(5);

        // Reset in the middle of data bit 4 of 0xFF.
        rx_in = 1'b0;
        repeat (CLK_DIV) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (CLK_DIV / 2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", int'({data_out, data_valid, sipo_shift, sipo_d, busy, frame_err, overrun, parity_err}), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_held = 0;
        idle(CLK_DIV * 2);
        send_frame(8'h0F, 1, 0);
        idle(6);
        chk("post_reset_byte", int'(data_out), 8'h0F);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1, 0);
        idle(6);
        send_frame(8'h07, 1, 1);
        idle(6);
`endif

        // Randomised frames, errors and host stalls.
        for (int n = 0; n < 24; n++) begin
            set_ready($urandom_range(0, 3) != 0);
            send_frame(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0);
            idle($urandom_range(3, 25));
        end
        set_ready(1);
        idle(20);

        chk("events_left", exp_kind_q.size(), 0);
        chk("episodes_left", exp_shifts_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete (checks %0d)", n_checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
